// File: rtl/aes_ctr_sched.sv
// -----------------------------------------------------------------------------
// aes_ctr_sched
//
// Round-robin scheduler that shares one sliced CTR-mode counter incrementer
// among NumReq requesters. Only one increment is in flight at a time.
// The scheduler picks a winner, pulses the incrementer's increment request
// for one cycle, waits for the incrementer to report ready again, and then
// acknowledges the winner. A watchdog bounds the wait. Both a timeout and an
// alert from the incrementer lock the scheduler into a terminal error state.
// Only reset leaves that state.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous, active-low reset
//   req_i        per-requester increment request (level, held until ack)
//   ack_o        one-cycle completion pulse to the granted requester
//   gnt_idx_o    index of the current or last winner
//   busy_o       high while an increment is being issued or awaited
//   ctr_incr_o   one-cycle increment request to the incrementer
//   ctr_ready_i  incrementer idle and able to accept an increment
//   ctr_alert_i  incrementer alert; forces the terminal error state
//   alert_o      scheduler is in the terminal error state
// -----------------------------------------------------------------------------
module aes_ctr_sched #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned SliceIdxWidth = 3,
    parameter int unsigned TimeoutCycles = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumReq-1:0]         req_i,
    output logic [NumReq-1:0]         ack_o,
    output logic [$clog2(NumReq)-1:0] gnt_idx_o,
    output logic                      busy_o,
    output logic                      ctr_incr_o,
    input  logic                      ctr_ready_i,
    input  logic                      ctr_alert_i,
    output logic                      alert_o
);

    localparam int unsigned IdxW       = $clog2(NumReq);
    localparam int unsigned IncrCycles = 2 ** SliceIdxWidth;
    // A healthy increment must never trip the watchdog. If the timeout is
    // configured too small, it is clamped to one cycle past the busy window.
    localparam int unsigned TimeoutLimit =
        (TimeoutCycles > IncrCycles) ? TimeoutCycles : IncrCycles + 1;
    localparam int unsigned WdW = $clog2(TimeoutLimit + 1);

    // Each pair of encodings is at least 3 bits apart. A single upset can
    // therefore never turn one legal state into another.
    typedef enum logic [4:0] {
        StIdle  = 5'b10100,
        StIssue = 5'b10011,
        StWait  = 5'b01101,
        StError = 5'b01010
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [WdW-1:0]  wdog_q, wdog_d;
    logic            incr_q;
    logic            busy_q;
    logic            alert_q;

    logic [IdxW-1:0] winner;
    logic [IdxW-1:0] cand;
    logic            found;

    // Round-robin search: start one above the last served requester and wrap.
    // The first hit wins.
    always_comb begin
        winner = last_q;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= int'(NumReq); k++) begin
            cand = IdxW'((int'(last_q) + k) % int'(NumReq));
            if (!found && req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        ack_o   = '0;

        case (state_q)
            StIdle: begin
                if (ctr_ready_i && (req_i != '0)) begin
                    gnt_d   = winner;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                if (ctr_ready_i) begin
                    ack_o[gnt_q] = 1'b1;
                    last_d       = gnt_q;
                    state_d      = StIdle;
                end else begin
                    // Saturate instead of wrapping so the count cannot
                    // roll back under the limit.
                    if (wdog_q != WdW'(TimeoutLimit)) begin
                        wdog_d = wdog_q + 1'b1;
                    end
                    if (int'(wdog_q) + 1 >= int'(TimeoutLimit)) begin
                        state_d = StError;
                    end
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StError;
            end
        endcase

        // An incrementer alert wins over everything, including an ack in
        // the same cycle. No requester is told that its increment completed.
        if (ctr_alert_i) begin
            state_d = StError;
            ack_o   = '0;
            last_d  = last_q;
        end

        if (state_d == StError) begin
            gnt_d = '0;
        end
    end

    // The registered outputs are decoded from the next state. Each one
    // therefore lines up with the state register it describes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            last_q  <= IdxW'(NumReq - 1);
            wdog_q  <= '0;
            incr_q  <= 1'b0;
            busy_q  <= 1'b0;
            alert_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            incr_q  <= (state_d == StIssue);
            busy_q  <= (state_d == StIssue) || (state_d == StWait);
            alert_q <= (state_d == StError);
        end
    end

    assign gnt_idx_o  = gnt_q;
    assign busy_o     = busy_q;
    assign ctr_incr_o = incr_q;
    assign alert_o    = alert_q;

endmodule

// File: tb/tb_aes_ctr_sched.sv
// -----------------------------------------------------------------------------
// Testbench for aes_ctr_sched (default parameters).
// A small incrementer model drives ctr_ready_i: after it sees ctr_incr_o,
// it is busy for 2**SliceIdxWidth cycles. Expected grant indices are queued
// when requests are driven, and they are popped when an ack appears.
// Inputs change on the falling edge, or 1 time unit after the rising edge.
// Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_aes_ctr_sched;

    localparam int NumReq        = 2;
    localparam int SliceIdxWidth = 3;
    localparam int TimeoutCycles = 12;
    localparam int IncrCycles    = 2 ** SliceIdxWidth;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [1:0] req     = 2'b00;
    logic [1:0] ack;
    logic [0:0] gnt;
    logic       busy;
    logic       incr;
    logic       ready;
    logic       calert  = 1'b0;
    logic       alert;
    logic       hold_low = 1'b0;
    int         inc_busy;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    aes_ctr_sched #(
        .NumReq        (NumReq),
        .SliceIdxWidth (SliceIdxWidth),
        .TimeoutCycles (TimeoutCycles)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .ack_o       (ack),
        .gnt_idx_o   (gnt),
        .busy_o      (busy),
        .ctr_incr_o  (incr),
        .ctr_ready_i (ready),
        .ctr_alert_i (calert),
        .alert_o     (alert)
    );

    // Incrementer model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              inc_busy <= 0;
        else if (incr)           inc_busy <= IncrCycles;
        else if (inc_busy > 0)   inc_busy <= inc_busy - 1;
    end
    assign ready = (inc_busy == 0) && !hold_low;

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = 2'b00;
        hold_low = 1'b0;
        calert   = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits for the next nonzero ack (bounded). Then it checks the ack
    // against the queued expectation.
    task automatic wait_ack(input int budget, output int waited);
        int         exp_idx;
        logic [1:0] exp_ack;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (ack === 2'b00 && waited < budget);
        n_vec++;
        if (ack === 2'b00) begin
            n_err++;
            $display("FAIL ack_wait: ack_o=%b after %0d cycles, required a nonzero ack", ack, waited);
        end else begin
            exp_idx = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            exp_ack = (exp_idx >= 0) ? (2'b01 << exp_idx) : 2'b00;
            $display("ack_o=%b gnt_idx_o=%0d after %0d cycles (expected requester %0d)",
                     ack, gnt, waited, exp_idx);
            n_vec++;
            if (ack !== exp_ack) begin
                n_err++;
                $display("FAIL ack_value: ack_o=%b, required %b", ack, exp_ack);
            end
            n_vec++;
            if (exp_idx < 0 || gnt !== 1'(exp_idx)) begin
                n_err++;
                $display("FAIL ack_gnt_idx: gnt_idx_o=%0d, required %0d", gnt, exp_idx);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        #1;
        n_vec++;
        if ({ack, gnt, busy, incr, alert} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: ack=%b gnt=%0d busy=%b incr=%b alert=%b, required all 0",
                     ack, gnt, busy, incr, alert);
        end
        do_reset();
        n_vec++;
        if ({ack, gnt, busy, incr, alert} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_release: ack=%b gnt=%0d busy=%b incr=%b alert=%b, required all 0",
                     ack, gnt, busy, incr, alert);
        end
        $display("reset: outputs sampled");
    endtask

    task automatic test_single();
        int w;
        do_reset();
        req = 2'b01;
        exp_q.push_back(0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            n_vec++;
            if (incr !== (c == 1) || busy !== 1'b1 || ack !== 2'b00) begin
                n_err++;
                $display("FAIL single_cycle%0d: incr=%b busy=%b ack=%b, required incr=%b busy=1 ack=00",
                         c, incr, busy, ack, (c == 1));
            end
        end
        wait_ack(5, w);
        n_vec++;
        if (w != 1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_ack_cycle: ack at cycle %0d busy=%b, required cycle 10 busy=1", 9 + w, busy);
        end
        req = 2'b00;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || incr !== 1'b0 || ack !== 2'b00 || gnt !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: busy=%b incr=%b ack=%b gnt=%0d, required 0 0 00 0",
                     busy, incr, ack, gnt);
        end
    endtask

    task automatic test_contention();
        int w;
        do_reset();
        req = 2'b11;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(0);
        for (int op = 0; op < 3; op++) begin
            wait_ack(20, w);
            n_vec++;
            if (w != ((op == 0) ? 10 : 11)) begin
                n_err++;
                $display("FAIL contention_spacing%0d: %0d cycles, required %0d", op, w, (op == 0) ? 10 : 11);
            end
        end
        req = 2'b00;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL contention_queue: %0d expectations left, required 0", exp_q.size());
        end
    endtask

    task automatic test_ready_low();
        int w;
        do_reset();
        hold_low = 1'b1;
        req      = 2'b10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (incr !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL ready_low_cycle%0d: incr=%b busy=%b, required 0 0", c, incr, busy);
            end
        end
        hold_low = 1'b0;
        exp_q.push_back(1);
        @(negedge clk);
        n_vec++;
        if (incr !== 1'b1 || gnt !== 1'b1) begin
            n_err++;
            $display("FAIL ready_low_grant: incr=%b gnt=%0d, required 1 1", incr, gnt);
        end
        wait_ack(20, w);
        n_vec++;
        if (w != 9) begin
            n_err++;
            $display("FAIL ready_low_latency: %0d cycles after issue, required 9", w);
        end
        req = 2'b00;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 2'b01;
        @(negedge clk);
        n_vec++;
        if (incr !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_issue: incr=%b, required 1", incr);
        end
        hold_low = 1'b1;
        for (int c = 2; c <= 13; c++) begin
            @(negedge clk);
            n_vec++;
            if (alert !== 1'b0 || ack !== 2'b00 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL timeout_wait%0d: alert=%b ack=%b busy=%b, required 0 00 1", c, alert, ack, busy);
            end
        end
        @(negedge clk);
        n_vec++;
        if (alert !== 1'b1 || busy !== 1'b0 || incr !== 1'b0 || ack !== 2'b00 || gnt !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_error: alert=%b busy=%b incr=%b ack=%b gnt=%0d, required 1 0 0 00 0",
                     alert, busy, incr, ack, gnt);
        end
        $display("timeout: alert_o=%b after 12 wait cycles", alert);
        hold_low = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (alert !== 1'b1 || ack !== 2'b00 || incr !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_sticky%0d: alert=%b ack=%b incr=%b, required 1 00 0", c, alert, ack, incr);
            end
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (alert !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_reset_clear: alert=%b, required 0", alert);
        end
        do_reset();
    endtask

    task automatic test_alert_override();
        do_reset();
        req = 2'b01;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 calert = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ack !== 2'b00 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL override_ack: ack=%b busy=%b, required 00 1", ack, busy);
        end
        @(posedge clk);
        #1 calert = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec++;
            if (alert !== 1'b1 || ack !== 2'b00 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL override_error%0d: alert=%b ack=%b busy=%b, required 1 00 0", c, alert, ack, busy);
            end
        end
        $display("alert override: alert_o=%b", alert);
        req = 2'b00;
    endtask

    task automatic test_reset_mid_wait();
        int w;
        do_reset();
        req = 2'b01;
        exp_q.push_back(0);
        wait_ack(20, w);
        req = 2'b10;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (incr !== 1'b1 || gnt !== 1'b1) begin
            n_err++;
            $display("FAIL midwait_second_grant: incr=%b gnt=%0d, required 1 1", incr, gnt);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ack, gnt, busy, incr, alert} !== 6'b0) begin
            n_err++;
            $display("FAIL midwait_reset: ack=%b gnt=%0d busy=%b incr=%b alert=%b, required all 0",
                     ack, gnt, busy, incr, alert);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 2'b11;
        exp_q.push_back(0);
        @(negedge clk);
        n_vec++;
        if (incr !== 1'b1 || gnt !== 1'b0) begin
            n_err++;
            $display("FAIL midwait_priority: incr=%b gnt=%0d, required 1 0", incr, gnt);
        end
        wait_ack(20, w);
        req = 2'b00;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL midwait_queue: %0d expectations left, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_ready_low();
        test_timeout();
        test_alert_override();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units, required completion");
        $fatal(1);
    end

endmodule
